// File: rtl/blob_pkg.sv
// Shared constants and FSM state type for the blob motion controller.
// Screen geometry, coordinate widths and the frame-update sequencer states.
// Compile-time option BLOB_MOTION_WRAP_EN (see blob_axis_step) selects wrap instead of bounce.
package blob_pkg;

  localparam int SCREEN_W = 1024;
  localparam int SCREEN_H = 768;

  // Output coordinate widths and the internal arithmetic width.
  localparam int XW = 11;
  localparam int YW = 10;
  localparam int CW = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC_X = 2'd1,
    CALC_Y = 2'd2,
    COMMIT = 2'd3
  } state_e;

endpackage

// File: rtl/blob_axis_step.sv
// One-axis next position / direction / edge event for the blob sprite.
// Purely combinational; the parent time-shares it between the x and y axes.
// Macro BLOB_MOTION_WRAP_EN: toroidal wrap at the limits instead of bouncing.
module blob_axis_step
  import blob_pkg::*;
(
  input  logic [CW-1:0] pos,
  input  logic          dir,   // 1 = increasing coordinate
  input  logic [3:0]    s,
  input  logic [CW-1:0] max,
  output logic [CW-1:0] npos,
  output logic          ndir,
  output logic          evt
);

  logic [CW-1:0] s_ext;
  logic [CW-1:0] sum;

  assign s_ext = {{(CW-4){1'b0}}, s};
  assign sum   = pos + s_ext;

  // Zero speed never moves and never raises an edge event, even at a limit.
  always_comb begin
    npos = pos;
    ndir = dir;
    evt  = 1'b0;
    if (s != 4'd0) begin
`ifdef BLOB_MOTION_WRAP_EN
      if (dir) begin
        if (sum > max) begin
          npos = sum - (max + CW'(1));
          evt  = 1'b1;
        end else begin
          npos = sum;
        end
      end else begin
        if (pos < s_ext) begin
          npos = pos + (max + CW'(1)) - s_ext;
          evt  = 1'b1;
        end else begin
          npos = pos - s_ext;
        end
      end
`else
      if (dir) begin
        if (sum >= max) begin
          npos = max;
          ndir = 1'b0;
          evt  = 1'b1;
        end else begin
          npos = sum;
        end
      end else begin
        if (pos <= s_ext) begin
          npos = '0;
          ndir = 1'b1;
          evt  = 1'b1;
        end else begin
          npos = pos - s_ext;
        end
      end
`endif
    end
  end

endmodule

// File: rtl/blob_motion_ctrl.sv
// Per-frame blob sprite position controller: steps x/y once per vsync fall, bouncing off edges.
// Latency: new x/y and the update_done/bounce pulses appear 3 clocks after the edge-detect cycle.
// Macro BLOB_MOTION_WRAP_EN selects toroidal wrap; a single axis stepper is shared by x and y.
module blob_motion_ctrl
  import blob_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64,
  parameter int INIT_X = 0,
  parameter int INIT_Y = 0
) (
  input  logic          vclock,
  input  logic          reset_n,
  input  logic          vsync,
  input  logic          enable,
  input  logic [3:0]    speed,
  input  logic          load,
  input  logic [XW-1:0] load_x,
  input  logic [YW-1:0] load_y,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          update_done,
  output logic          bounce_x,
  output logic          bounce_y
);

  localparam logic [CW-1:0] XMAX = CW'(SCREEN_W - WIDTH);
  localparam logic [CW-1:0] YMAX = CW'(SCREEN_H - HEIGHT);

  state_e        state_q;
  logic          vsync_q;
  logic          en_q;
  logic [3:0]    spd_q;
  logic [CW-1:0] nx_q, ny_q;
  logic          ndx_q, ndy_q, evx_q, evy_q;
  logic          dir_x_q, dir_y_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          done_q, bx_q, by_q;
  logic          pend_q;
  logic [CW-1:0] pend_x_q, pend_y_q;

  logic          frame_edge;
  logic          on_y;
  logic [CW-1:0] step_pos, step_max, step_npos;
  logic [3:0]    step_s;
  logic          step_dir, step_ndir, step_evt;
  logic [CW-1:0] lx_ext, ly_ext, lx_clamp, ly_clamp;
  logic          unused_hi;

  assign frame_edge = vsync_q & ~vsync;

  // Stepper operand mux: x axis with live speed in CALC_X, y axis with latched speed in CALC_Y.
  assign on_y     = (state_q == CALC_Y);
  assign step_pos = on_y ? {{(CW-YW){1'b0}}, y_q} : {{(CW-XW){1'b0}}, x_q};
  assign step_dir = on_y ? dir_y_q : dir_x_q;
  assign step_s   = on_y ? spd_q : speed;
  assign step_max = on_y ? YMAX : XMAX;

  blob_axis_step u_step (
    .pos  (step_pos),
    .dir  (step_dir),
    .s    (step_s),
    .max  (step_max),
    .npos (step_npos),
    .ndir (step_ndir),
    .evt  (step_evt)
  );

  // Teleport targets are clamped on capture so the stored position is always on screen.
  assign lx_ext   = {{(CW-XW){1'b0}}, load_x};
  assign ly_ext   = {{(CW-YW){1'b0}}, load_y};
  assign lx_clamp = (lx_ext > XMAX) ? XMAX : lx_ext;
  assign ly_clamp = (ly_ext > YMAX) ? YMAX : ly_ext;

  // Upper bits are always zero because every stored value is bounded by XMAX/YMAX.
  assign unused_hi = ^{nx_q[CW-1:XW], ny_q[CW-1:YW], pend_x_q[CW-1:XW], pend_y_q[CW-1:YW]};

  // Frame sequencer: detect, compute x, compute y, commit; pulses are registered one-cycle outputs.
  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      vsync_q  <= 1'b1;
      en_q     <= 1'b0;
      spd_q    <= '0;
      nx_q     <= '0;
      ny_q     <= '0;
      ndx_q    <= 1'b1;
      ndy_q    <= 1'b1;
      evx_q    <= 1'b0;
      evy_q    <= 1'b0;
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b1;
      x_q      <= XW'(INIT_X);
      y_q      <= YW'(INIT_Y);
      done_q   <= 1'b0;
      bx_q     <= 1'b0;
      by_q     <= 1'b0;
      pend_q   <= 1'b0;
      pend_x_q <= '0;
      pend_y_q <= '0;
    end else begin
      vsync_q <= vsync;
      done_q  <= 1'b0;
      bx_q    <= 1'b0;
      by_q    <= 1'b0;
      if (load) begin
        pend_q   <= 1'b1;
        pend_x_q <= lx_clamp;
        pend_y_q <= ly_clamp;
      end
      case (state_q)
        IDLE: begin
          if (frame_edge) begin
            en_q    <= enable;
            state_q <= CALC_X;
          end
        end
        CALC_X: begin
          nx_q    <= step_npos;
          ndx_q   <= step_ndir;
          evx_q   <= step_evt;
          spd_q   <= speed;
          state_q <= CALC_Y;
        end
        CALC_Y: begin
          ny_q    <= step_npos;
          ndy_q   <= step_ndir;
          evy_q   <= step_evt;
          state_q <= COMMIT;
        end
        COMMIT: begin
          done_q <= 1'b1;
          if (pend_q) begin
            x_q <= pend_x_q[XW-1:0];
            y_q <= pend_y_q[YW-1:0];
          end else if (en_q) begin
            x_q     <= nx_q[XW-1:0];
            y_q     <= ny_q[YW-1:0];
            dir_x_q <= ndx_q;
            dir_y_q <= ndy_q;
            bx_q    <= evx_q;
            by_q    <= evy_q;
          end
          // A load arriving now is kept for the next frame.
          if (!load) begin
            pend_q <= 1'b0;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign update_done = done_q;
  assign bounce_x    = bx_q;
  assign bounce_y    = by_q;

endmodule

// File: tb/tb_blob_motion_ctrl.sv
// Self-checking bench for blob_motion_ctrl: frame table, corner sequences, random frames vs model.
module tb_blob_motion_ctrl;

  localparam int XMAX = 1024 - 64;
  localparam int YMAX = 768 - 64;

  logic        vclock = 1'b0;
  logic        reset_n;
  logic        vsync;
  logic        enable;
  logic [3:0]  speed;
  logic        load;
  logic [10:0] load_x;
  logic [9:0]  load_y;
  logic [10:0] x;
  logic [9:0]  y;
  logic        update_done;
  logic        bounce_x;
  logic        bounce_y;

  int tests = 0;
  int fails = 0;

  // Reference state: position, direction (1 = increasing), pending teleport.
  int m_x, m_y, m_px, m_py;
  bit m_dx, m_dy, m_pend, m_bx, m_by;

  int got_x, got_y;
  bit got_bx, got_by;

  typedef struct {
    bit ld; int lx; int ly; bit en; int spd;
    int ex; int ey; bit ebx; bit eby;
  } vec_t;
  vec_t tbl[$];

  blob_motion_ctrl dut (
    .vclock      (vclock),
    .reset_n     (reset_n),
    .vsync       (vsync),
    .enable      (enable),
    .speed       (speed),
    .load        (load),
    .load_x      (load_x),
    .load_y      (load_y),
    .x           (x),
    .y           (y),
    .update_done (update_done),
    .bounce_x    (bounce_x),
    .bounce_y    (bounce_y)
  );

  always #5 vclock = ~vclock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_dx = 1; m_dy = 1; m_pend = 0; m_px = 0; m_py = 0;
    m_bx = 0; m_by = 0;
  endtask

  task automatic model_load(input int lx, input int ly);
    m_pend = 1;
    m_px = (lx > XMAX) ? XMAX : lx;
    m_py = (ly > YMAX) ? YMAX : ly;
  endtask

  // One axis step from the movement rules, in plain integer arithmetic.
  task automatic mstep(input int p, input bit d, input int s, input int mx,
                       output int np, output bit nd, output bit ev);
    np = p; nd = d; ev = 0;
    if (s != 0) begin
`ifdef BLOB_MOTION_WRAP_EN
      if (d) begin
        ev = (p + s > mx);
        np = (p + s) % (mx + 1);
      end else begin
        ev = (p < s);
        np = (p - s + mx + 1) % (mx + 1);
      end
`else
      if (d) begin
        if (p + s >= mx) begin np = mx; nd = 0; ev = 1; end
        else np = p + s;
      end else begin
        if (p <= s) begin np = 0; nd = 1; ev = 1; end
        else np = p - s;
      end
`endif
    end
  endtask

  task automatic model_frame(input bit en, input int spd);
    int nx, ny;
    bit ndx, ndy;
    m_bx = 0; m_by = 0;
    if (m_pend) begin
      m_x = m_px; m_y = m_py; m_pend = 0;
    end else if (en) begin
      mstep(m_x, m_dx, spd, XMAX, nx, ndx, m_bx);
      mstep(m_y, m_dy, spd, YMAX, ny, ndy, m_by);
      m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; vsync = 1'b1; load = 1'b0; enable = 1'b0;
    speed = 4'd0; load_x = '0; load_y = '0;
    repeat (2) @(posedge vclock);
    #1;
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_pulses", int'({update_done, bounce_x, bounce_y}), 0);
    reset_n = 1'b1;
    @(posedge vclock); #1;
    model_reset();
  endtask

  // Optional one-cycle load, then a full frame; checks timing, pulses and position vs model.
  task automatic run_frame(input bit ld, input int lx, input int ly, input bit en, input int spd);
    if (ld) begin
      load = 1'b1; load_x = 11'(lx); load_y = 10'(ly);
      @(posedge vclock); #1;
      load = 1'b0;
      model_load(lx, ly);
    end
    vsync = 1'b0; enable = en; speed = 4'(spd);
    @(posedge vclock); #1;            // edge-detect clock
    enable = ~en;                     // enable is only sampled at the edge
    @(posedge vclock); #1;            // CALC_X done, speed latched
    speed = 4'(~spd);                 // y must use the latched speed
    @(posedge vclock); #1;            // now in COMMIT
    check("early_done", int'(update_done), 0);
    check("hold_x", int'(x), m_x);
    model_frame(en, spd);
    @(posedge vclock); #1;            // 3 clocks after edge detect
    got_x = int'(x); got_y = int'(y); got_bx = bounce_x; got_by = bounce_y;
    check("done_pulse", int'(update_done), 1);
    check("frame_x", got_x, m_x);
    check("frame_y", got_y, m_y);
    check("frame_bx", int'(got_bx), int'(m_bx));
    check("frame_by", int'(got_by), int'(m_by));
    vsync = 1'b1;
    @(posedge vclock); #1;
    check("pulse_len", int'({update_done, bounce_x, bounce_y}), 0);
    @(posedge vclock); #1;
  endtask

  initial begin
    // Expected positions walk from reset through loads, edges, zero speed and disabled frames.
`ifdef BLOB_MOTION_WRAP_EN
    tbl.push_back('{1'b1, 958, 10, 1'b0, 4,   958, 10, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 0,   0,  1'b1, 4,   1,   14, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 2,   700, 1'b0, 4,  2,   700, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 0,   0,  1'b1, 4,   6,   704, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 0,   0,  1'b1, 4,   10,  3,   1'b0, 1'b1});
    tbl.push_back('{1'b0, 0,   0,  1'b1, 0,   10,  3,   1'b0, 1'b0});
`else
    tbl.push_back('{1'b0, 0,    0,   1'b1, 4,  4,   4,   1'b0, 1'b0});
    tbl.push_back('{1'b1, 958,  10,  1'b0, 4,  958, 10,  1'b0, 1'b0});
    tbl.push_back('{1'b0, 0,    0,   1'b1, 4,  960, 14,  1'b1, 1'b0});
    tbl.push_back('{1'b0, 0,    0,   1'b1, 4,  956, 18,  1'b0, 1'b0});
    tbl.push_back('{1'b1, 2000, 700, 1'b0, 7,  960, 700, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 0,    0,   1'b1, 4,  956, 704, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 500,  3,   1'b0, 0,  500, 3,   1'b0, 1'b0});
    tbl.push_back('{1'b0, 0,    0,   1'b1, 3,  497, 0,   1'b0, 1'b1});
    tbl.push_back('{1'b0, 0,    0,   1'b1, 3,  494, 3,   1'b0, 1'b0});
    tbl.push_back('{1'b0, 0,    0,   1'b1, 0,  494, 3,   1'b0, 1'b0});
    tbl.push_back('{1'b0, 0,    0,   1'b0, 9,  494, 3,   1'b0, 1'b0});
    tbl.push_back('{1'b1, 0,    0,   1'b0, 5,  0,   0,   1'b0, 1'b0});
    tbl.push_back('{1'b0, 0,    0,   1'b1, 0,  0,   0,   1'b0, 1'b0});
    tbl.push_back('{1'b0, 0,    0,   1'b1, 1,  0,   1,   1'b1, 1'b0});
    tbl.push_back('{1'b0, 0,    0,   1'b1, 15, 15,  16,  1'b0, 1'b0});
`endif

    do_reset();
    foreach (tbl[i]) begin
      run_frame(tbl[i].ld, tbl[i].lx, tbl[i].ly, tbl[i].en, tbl[i].spd);
      check($sformatf("tbl%0d_x", i), got_x, tbl[i].ex);
      check($sformatf("tbl%0d_y", i), got_y, tbl[i].ey);
      check($sformatf("tbl%0d_b", i), int'({got_bx, got_by}), int'({tbl[i].ebx, tbl[i].eby}));
    end

    // Reset asserted while the sequencer is in CALC_Y: no commit, no done pulse.
    do_reset();
    run_frame(1'b0, 0, 0, 1'b1, 5);
    vsync = 1'b0; enable = 1'b1; speed = 4'd2;
    @(posedge vclock); #1;
    @(posedge vclock); #1;
    reset_n = 1'b0;
    #1;
    check("rst_mid_x", int'(x), 0);
    check("rst_mid_y", int'(y), 0);
    @(posedge vclock); #1;
    vsync = 1'b1;
    reset_n = 1'b1;
    model_reset();
    begin
      int seen = 0;
      for (int c = 0; c < 6; c++) begin
        @(posedge vclock); #1;
        if (update_done) seen++;
      end
      check("rst_mid_no_done", seen, 0);
    end
    run_frame(1'b0, 0, 0, 1'b1, 2);

    // A load raised during COMMIT is not applied until the following frame.
    do_reset();
    vsync = 1'b0; enable = 1'b1; speed = 4'd1;
    @(posedge vclock); #1;
    @(posedge vclock); #1;
    @(posedge vclock); #1;
    load = 1'b1; load_x = 11'd100; load_y = 10'd50;
    @(posedge vclock); #1;
    load = 1'b0;
    model_frame(1'b1, 1);
    check("defer_x", int'(x), m_x);
    check("defer_y", int'(y), m_y);
    model_load(100, 50);
    vsync = 1'b1;
    repeat (2) @(posedge vclock);
    #1;
    run_frame(1'b0, 0, 0, 1'b0, 3);
    check("defer_applied_x", got_x, 100);

    // Randomised frames against the reference model.
    do_reset();
    for (int f = 0; f < 60; f++) begin
      run_frame($urandom_range(0, 3) == 0, int'($urandom_range(0, 2047)),
                int'($urandom_range(0, 1023)), $urandom_range(0, 3) != 0,
                int'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/blob_motion_ctrl.md
Name: blob_motion_ctrl

Overview:
- Per-frame position controller for one rectangular blob sprite.
- Steps the sprite's top-left x/y once per video frame, at the start of vertical sync, so the on-screen position never changes mid-frame.
- Bounces the sprite off the screen edges.
- Sits between the xvga timing generator and the blob pixel generator; drives that generator's x/y inputs.

Parameters:
- WIDTH, 64, sprite width in pixels.
- HEIGHT, 64, sprite height in pixels.
- INIT_X, 0, reset x position.
- INIT_Y, 0, reset y position.

Ports:
- vclock  in  1  video clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- vsync  in  1  active-low vertical sync from the timing generator.
- enable  in  1  motion enable; sampled on the vsync edge.
- speed  in  4  pixels per frame on both axes; sampled in CALC_X.
- load  in  1  one-cycle request to teleport the sprite.
- load_x  in  11  teleport x.
- load_y  in  10  teleport y.
- x  out  11  sprite left edge.
- y  out  10  sprite top edge.
- update_done  out  1  one-cycle pulse when x/y commit.
- bounce_x  out  1  one-cycle pulse on an x edge event.
- bounce_y  out  1  one-cycle pulse on a y edge event.

Behaviour:
- Reset (async, reset_n=0):
  - x=INIT_X, y=INIT_Y.
  - dir_x=+, dir_y=+ (right/down).
  - State IDLE; vsync_d=1; load pending cleared; all pulse outputs 0.
- Limits: XMAX=SCREEN_W-WIDTH, YMAX=SCREEN_H-HEIGHT. All arithmetic is unsigned at 12 bits, so no overflow is possible.
- Edge detect: vsync_d is a registered copy of vsync. The frame edge is the cycle where vsync_d=1 and vsync=0.
- FSM states: IDLE, CALC_X, CALC_Y, COMMIT.
  - IDLE -> CALC_X on the frame edge. Otherwise stay in IDLE.
  - CALC_X: compute nx and the new dir_x; latch speed. Go to CALC_Y.
  - CALC_Y: compute ny and the new dir_y using the same latched speed. Go to COMMIT.
  - COMMIT: x<=nx and y<=ny; update_done=1; bounce_x/bounce_y pulse if flagged. Go to IDLE.
- Latency: new x/y are visible 3 clocks after the edge-detect cycle. A second vsync falling edge cannot occur within 4 cycles.
- Step rule for positive direction, s = speed:
  - If pos+s >= MAX: pos=MAX, direction reverses, bounce pulse.
  - Else: pos=pos+s.
- Step rule for negative direction:
  - If pos <= s: pos=0, direction reverses, bounce pulse.
  - Else: pos=pos-s.
- Exactly landing on 0 or MAX counts as a bounce.
- speed=0: no motion and no bounce pulses, even when sitting at a limit.
- enable=0 at the edge: the FSM still runs and update_done still pulses, but the computed motion is discarded (x/y/dir hold).
- load:
  - Latched into a pending register on any cycle; a later load overwrites it.
  - Applied at the next COMMIT instead of the computed position, regardless of enable.
  - Values are clamped to XMAX/YMAX. Directions are unchanged and no bounce pulse is generated.
  - A load in the COMMIT cycle itself is deferred to the following frame.
- Reset asserted mid-sequence: immediate return to the reset state; no partial commit.

Optional Feature:
- Macro: BLOB_MOTION_WRAP_EN.
- Defined: toroidal wrap instead of bounce.
  - Positive direction: pos+s > MAX gives pos=pos+s-(MAX+1).
  - Negative direction: pos < s gives pos=pos+(MAX+1)-s.
  - Direction never changes. bounce_x/bounce_y pulse on a wrap.
- Undefined: bounce behaviour as above.

Decomposition:
- Package blob_pkg holds:
  - SCREEN_W=1024, SCREEN_H=768.
  - Coordinate width constants (11, 10, 12-bit internal).
  - The FSM state typedef.
- Sub-module blob_axis_step: combinational next-position/direction/event for one axis, with inputs pos, dir, s, max.
  - A single instance is time-shared: its max input is muxed XMAX in CALC_X and YMAX in CALC_Y.
  - This sharing is the reason for the sequenced FSM.

Test Plan:
- Reset, speed=4, enable=1, one vsync fall -> exactly 3 clocks after edge detect: x=4, y=4, update_done pulses once, no bounce pulses.
- x=958, dir_x=+, speed=4, frame edge -> x=960 (XMAX), bounce_x=1 in COMMIT; next frame x=956.
- y=3, dir_y=-, speed=3, frame edge -> y=0, bounce_y=1, dir_y=+; next frame y=3.
- load with load_x=2000, load_y=700 mid-frame, enable=0 -> next COMMIT gives x=960, y=700; no bounce pulse; update_done pulses.
- reset_n low during CALC_Y -> x/y return to INIT_X/INIT_Y immediately; no update_done pulse that frame.
- BLOB_MOTION_WRAP_EN defined, x=958, dir_x=+, speed=4 -> x=1; dir unchanged; bounce_x pulses.
